// File: rtl/iobuf_seq_pkg.sv
// Shared types for the IOBUF bus sequencer.
//   state_t : sequencer FSM states
//   dir_t   : current bus direction as seen from the fabric side
//   max3    : helper for sizing the dwell counter
package iobuf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  typedef enum logic {
    RELEASED = 1'b0,
    DRIVEN   = 1'b1
  } dir_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iob_dwell_counter.sv
// Down-counter that times how long the sequencer dwells in a state.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : strobe on state entry; count takes load_val (= cycles - 1)
//   load_val   : value loaded by the strobe
//   done       : high in the last cycle of the dwell (count reached zero)
module iob_dwell_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/iobuf_bus_sequencer.sv
// Half-duplex controller for WIDTH IOBUF cells sharing one external bus.
// Owns the T pins so the bus is never contended: every direction change goes
// through TURN dead time, writes are driven for DRIVE_CYCLES before the ack,
// reads wait SAMPLE_CYCLES with the bus released before capturing pad_o.
//   cmd_valid/cmd_ready/cmd_write/cmd_wdata : single-word command in
//   rsp_valid/rsp_write/rsp_rdata           : one-cycle response pulse out
//   pad_i/pad_t/pad_o                       : IOBUF I, T (1 = released), O
//   bus_driven                              : 1 while pad_t is all zeros
module iobuf_bus_sequencer
  import iobuf_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned TURN_CYCLES   = 2,
  parameter int unsigned DRIVE_CYCLES  = 1,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter bit          PARK_DRIVEN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_o,
  output logic             bus_driven
);

  localparam int unsigned CNT_W = $clog2(max3(TURN_CYCLES, DRIVE_CYCLES, SAMPLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD  = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

  typedef struct packed {
    logic             write;
    logic [WIDTH-1:0] wdata;
  } pending_op_t;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  pending_op_t      pend_q, pend_d;
  logic [WIDTH-1:0] pad_i_q, pad_i_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_write_q, rsp_write_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;

  iob_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= RELEASED;
      pend_q      <= '0;
      pad_i_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      pad_i_q     <= pad_i_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    pad_i_d     = pad_i_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pend_d   = '{write: cmd_write, wdata: cmd_wdata};
          cnt_load = 1'b1;
          if (cmd_write && dir_q == DRIVEN) begin
            // Already driving: no turnaround, present the new word at once.
            state_d = DRIVE;
            cnt_val = DRIVE_LOAD;
            pad_i_d = cmd_wdata;
          end else if (!cmd_write && dir_q == RELEASED) begin
            state_d = SETTLE;
            cnt_val = SAMPLE_LOAD;
          end else begin
            // Release in the first busy cycle so the far end never sees an
            // overlap between our drive and its response.
            state_d = TURN;
            cnt_val = TURN_LOAD;
            dir_d   = RELEASED;
          end
        end
      end

      TURN: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          if (pend_q.write) begin
            state_d = DRIVE;
            cnt_val = DRIVE_LOAD;
            dir_d   = DRIVEN;
            pad_i_d = pend_q.wdata;
          end else begin
            state_d = SETTLE;
            cnt_val = SAMPLE_LOAD;
          end
        end
      end

      DRIVE: begin
        if (cnt_done) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          dir_d       = PARK_DRIVEN ? DRIVEN : RELEASED;
        end
      end

      SETTLE: begin
        if (cnt_done) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = pad_o;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign pad_i      = pad_i_q;
  assign pad_t      = {WIDTH{dir_q == RELEASED}};
  assign bus_driven = (dir_q == DRIVEN);

endmodule

// File: tb/tb_iobuf_bus_sequencer.sv
// Scoreboard bench for iobuf_bus_sequencer (T=2, D=1, S=2).
// Main instance parks the bus driven; a second instance releases after writes.
module tb_iobuf_bus_sequencer;

  localparam int W = 8;
  localparam int T = 2;
  localparam int D = 1;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [W-1:0] cmd_wdata = '0;
  logic         rsp_valid, rsp_write;
  logic [W-1:0] rsp_rdata, pad_i, pad_t;
  logic [W-1:0] pad_o = '0;
  logic         bus_driven;

  logic         cmd_valid_np = 1'b0, cmd_ready_np, cmd_write_np = 1'b0;
  logic [W-1:0] cmd_wdata_np = '0;
  logic         rsp_valid_np, rsp_write_np;
  logic [W-1:0] rsp_rdata_np, pad_i_np, pad_t_np;
  logic [W-1:0] pad_o_np = '0;
  logic         bus_driven_np;

  iobuf_bus_sequencer #(
    .WIDTH(W), .TURN_CYCLES(T), .DRIVE_CYCLES(D), .SAMPLE_CYCLES(S), .PARK_DRIVEN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .pad_i(pad_i), .pad_t(pad_t),
    .pad_o(pad_o), .bus_driven(bus_driven)
  );

  iobuf_bus_sequencer #(
    .WIDTH(W), .TURN_CYCLES(T), .DRIVE_CYCLES(D), .SAMPLE_CYCLES(S), .PARK_DRIVEN(1'b0)
  ) dut_np (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_np), .cmd_ready(cmd_ready_np),
    .cmd_write(cmd_write_np), .cmd_wdata(cmd_wdata_np), .rsp_valid(rsp_valid_np),
    .rsp_write(rsp_write_np), .rsp_rdata(rsp_rdata_np), .pad_i(pad_i_np), .pad_t(pad_t_np),
    .pad_o(pad_o_np), .bus_driven(bus_driven_np)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         write;
    logic [W-1:0] rdata;
    int           at;
  } exp_t;

  exp_t sb_q[$];
  bit   rd_inflight = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: bus invariants every cycle, responses popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("pad_t_uniform", 32'(pad_t == '0 || pad_t == '1), 32'd1);
      check("bus_driven_flag", 32'(bus_driven), 32'(pad_t == '0));
      if (rd_inflight) check("read_bus_released", 32'(pad_t), 32'hFF);
      if (rsp_valid) begin
        check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_cycle", 32'(cyc), 32'(e.at));
          if (!e.write) rd_inflight = 1'b0;
        end
      end
    end
  end

  // Holds cmd_valid while busy; pad_o only changes once the DUT is idle so an
  // in-flight read is never disturbed.
  task automatic issue(input logic wr, input logic [W-1:0] wd, input logic [W-1:0] po,
                       input int lat, input logic [W-1:0] exp_rd, output int c0);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_wdata = wd;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    c0 = cyc;
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    pad_o = po;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_wdata = ~wd;
    sb_q.push_back('{write: wr, rdata: exp_rd, at: c0 + lat});
    if (!wr) rd_inflight = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_np(output int at, output bit any_drv);
    int n;
    n = 0;
    any_drv = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (pad_t_np != 8'hFF) any_drv = 1'b1;
    end while (!rsp_valid_np && n < 20);
    at = cyc;
    check("np_rsp_seen", 32'(rsp_valid_np), 32'd1);
  endtask

  int   c0, c1, at;
  bit   any_drv;
  bit   m_driven;
  logic [W-1:0] m_rdata;
  logic         wr;
  logic [W-1:0] wd, po;
  int           lat;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pad_t", 32'(pad_t), 32'hFF);
    check("rst_pad_i", 32'(pad_i), 32'h00);
    check("rst_bus_driven", 32'(bus_driven), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_write", 32'(rsp_write), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write 0xA5 from a released bus: TURN 1-2, DRIVE 3, rsp 4
    issue(1'b1, 8'hA5, 8'h00, 4, 8'h00, c0);
    @(negedge clk);
    check("wr_turn1_pad_t", 32'(pad_t), 32'hFF);
    check("wr_turn1_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("wr_turn2_pad_t", 32'(pad_t), 32'hFF);
    @(negedge clk);
    check("wr_drive_pad_t", 32'(pad_t), 32'h00);
    check("wr_drive_pad_i", 32'(pad_i), 32'hA5);
    @(negedge clk);
    check("wr_parked_driven", 32'(bus_driven), 32'd1);
    check("wr_parked_pad_i", 32'(pad_i), 32'hA5);

    // Back-to-back writes on the parked bus: rsp 2 cycles after each accept
    issue(1'b1, 8'h11, 8'h00, 2, 8'h00, c0);
    issue(1'b1, 8'h22, 8'h00, 2, 8'h00, c1);
    check("b2b_accept_gap", 32'(c1 - c0), 32'd2);
    drain();
    check("b2b_pad_i", 32'(pad_i), 32'h22);

    // Read after write: released from cycle 1, rsp cycle 5 with 0x3C
    issue(1'b0, 8'h00, 8'h3C, 5, 8'h3C, c0);
    @(negedge clk);
    check("rd_c1_pad_t", 32'(pad_t), 32'hFF);
    drain();
    check("rd_released_after", 32'(bus_driven), 32'd0);

    // Reset mid-DRIVE aborts the write with no response
    issue(1'b1, 8'h5A, 8'h00, 4, 8'h3C, c0);
    repeat (3) @(negedge clk);
    check("abort_in_drive", 32'(pad_t), 32'h00);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    rd_inflight = 1'b0;
    check("abort_pad_t", 32'(pad_t), 32'hFF);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_bus_driven", 32'(bus_driven), 32'd0);
    check("abort_rsp_rdata", 32'(rsp_rdata), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);

    // Release-after-write instance: write rsp at T+D+1, then read at S+1
    @(negedge clk);
    check("np_ready", 32'(cmd_ready_np), 32'd1);
    cmd_valid_np = 1'b1; cmd_write_np = 1'b1; cmd_wdata_np = 8'h77;
    c0 = cyc;
    @(posedge clk); #1;
    cmd_valid_np = 1'b0; cmd_wdata_np = 8'h00;
    wait_np(at, any_drv);
    check("np_write_latency", 32'(at - c0), 32'd4);
    check("np_write_rsp_write", 32'(rsp_write_np), 32'd1);
    check("np_released_after_write", 32'(pad_t_np), 32'hFF);
    check("np_bus_driven", 32'(bus_driven_np), 32'd0);
    cmd_valid_np = 1'b1; cmd_write_np = 1'b0; pad_o_np = 8'hC3;
    c0 = cyc;
    @(posedge clk); #1;
    cmd_valid_np = 1'b0; cmd_write_np = 1'b1;
    wait_np(at, any_drv);
    check("np_read_latency", 32'(at - c0), 32'd3);
    check("np_read_rdata", 32'(rsp_rdata_np), 32'hC3);
    check("np_read_rsp_write", 32'(rsp_write_np), 32'd0);
    check("np_read_never_driven", 32'(any_drv), 32'd0);

    // Random stress against a direction model
    m_driven = 1'b0;
    m_rdata  = 8'h00;
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom_range(0, 1));
      wd  = 8'($urandom);
      po  = 8'($urandom);
      if (wr) lat = m_driven ? D + 1 : T + D + 1;
      else    lat = m_driven ? T + S + 1 : S + 1;
      if (!wr) m_rdata = po;
      issue(wr, wd, po, lat, m_rdata, c0);
      m_driven = wr;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
